// File: rtl/bright_pkg.sv
// rtl/bright_pkg.sv - shared types and constants for the brightness frame sequencer
package bright_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DP_LAT     = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bright_addr_cnt.sv
// rtl/bright_addr_cnt.sv - clearable, enabled counter with terminal-count compare
// tc looks at the value the counter will hold after this cycle, so callers can act on the edge.
module bright_addr_cnt #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_nxt;

  assign count_nxt = count + W'(en);
  assign tc        = (count_nxt == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/bright_frame_ctrl.sv
// rtl/bright_frame_ctrl.sv - frame sequencer between pixel RAMs and the brightness datapath
// Optional abort input is built in when BRIGHT_FRAME_CTRL_ABORT_EN is defined.
module bright_frame_ctrl
  import bright_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        brightness_cfg,
  input  logic              pause,
`ifdef BRIGHT_FRAME_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dp_pixel,
  output logic              dp_valid,
  output logic [7:0]        dp_brightness,
  input  logic [DATA_W-1:0] dp_pixel_out,
  input  logic              dp_valid_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W:0] N_PIX = (ADDR_W+1)'(IMG_W * IMG_H);

  state_e          state;
  state_e          state_nxt;
  logic            start_acc;
  logic            abort_hit;
  logic            rd_pend;
  logic [ADDR_W:0] rd_cnt;
  logic [ADDR_W:0] wr_cnt;
  logic            rd_tc;
  logic            wr_tc;
  logic            unused_wr_msb;

`ifdef BRIGHT_FRAME_CTRL_ABORT_EN
  assign abort_hit = abort && (state == ST_RUN);
`else
  assign abort_hit = 1'b0;
`endif

  assign start_acc = (state == ST_IDLE) && start;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign rd_en     = (state == ST_RUN) && !pause && !abort_hit;
  assign rd_addr   = rd_cnt[ADDR_W-1:0];
  assign dp_pixel  = rd_data;
  assign dp_valid  = rd_pend;
  // Gated by busy so a datapath result still in flight across a reset is never written.
  assign wr_en     = dp_valid_out && busy;
  assign wr_data   = dp_pixel_out;
  assign wr_addr   = wr_cnt[ADDR_W-1:0];
  assign unused_wr_msb = wr_cnt[ADDR_W];

  bright_addr_cnt #(.W(ADDR_W+1)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .en    (rd_en),
    .limit (N_PIX),
    .count (rd_cnt),
    .tc    (rd_tc)
  );

  // Drain ends when writes catch up with reads issued, which also covers an aborted frame.
  bright_addr_cnt #(.W(ADDR_W+1)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .en    (wr_en),
    .limit (rd_cnt),
    .count (wr_cnt),
    .tc    (wr_tc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (abort_hit || (rd_en && rd_tc)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (wr_tc) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rd_pend       <= 1'b0;
      dp_brightness <= 8'd0;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_en;
      if (start_acc) dp_brightness <= brightness_cfg;
    end
  end

endmodule

// File: tb/tb_bright_frame_ctrl.sv
// tb/tb_bright_frame_ctrl.sv - randomized self-checking bench with a queue-based frame model
module tb_bright_frame_ctrl;

  localparam int BW = 4;
  localparam int BH = 4;
  localparam int BA = 4;
  localparam int BD = 8;
  localparam int NPIX = BW * BH;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    cfg;
  logic          pause;
  logic          busy, done, rd_en, dp_valid, wr_en, dp_valid_out;
  logic [BA-1:0] rd_addr, wr_addr;
  logic [BD-1:0] rd_data, dp_pixel, dp_pixel_out, wr_data;
  logic [7:0]    dp_brightness;
  logic          abort_sig;
`ifdef BRIGHT_FRAME_CTRL_ABORT_EN
  logic          abort;
  assign abort_sig = abort;
`else
  assign abort_sig = 1'b0;
`endif

  bright_frame_ctrl #(.IMG_W(BW), .IMG_H(BH), .ADDR_W(BA), .DATA_W(BD)) dut (
    .clk(clk), .rst(rst), .start(start), .brightness_cfg(cfg), .pause(pause),
`ifdef BRIGHT_FRAME_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .dp_pixel(dp_pixel), .dp_valid(dp_valid), .dp_brightness(dp_brightness),
    .dp_pixel_out(dp_pixel_out), .dp_valid_out(dp_valid_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int src [NPIX];
  int dst [NPIX];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: 1-cycle source RAM, saturating-subtract datapath, destination RAM.
  always @(posedge clk) begin
    if (rd_en) rd_data <= src[rd_addr][BD-1:0];
    dp_valid_out <= dp_valid;
    dp_pixel_out <= (dp_pixel > dp_brightness) ? dp_pixel - dp_brightness : '0;
    if (wr_en) dst[wr_addr] <= int'(wr_data);
  end

  function automatic int sat(input int p, input int b);
    return (p > b) ? p - b : 0;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Frame model: phase, counts, and a queue of reads awaiting their write slot.
  int m_phase = 0;
  int m_reads = 0, m_writes = 0, m_bright = 0;
  int q_addr[$];
  int q_due[$];
  bit m_prev_rd = 0;
  int m_prev_addr = 0;
  int m_start_cyc = 0;
  int done_cnt = 0, last_done_cyc = 0, fr_wr = 0;
  bit e_rd, e_wr;
  int ph;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", busy, 0);  chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0); chk("rst_rd_addr", rd_addr, 0);
      chk("rst_dp_valid", dp_valid, 0); chk("rst_bright", dp_brightness, 0);
      chk("rst_wr_en", wr_en, 0); chk("rst_wr_addr", wr_addr, 0);
      m_phase = 0; m_bright = 0; m_prev_rd = 0;
      q_addr.delete(); q_due.delete();
    end else begin
      e_rd = (m_phase == 1) && !pause && !abort_sig;
      e_wr = (q_due.size() > 0) && (q_due[0] == cyc);
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_phase == 3);
      chk("rd_en", rd_en, e_rd);
      if (e_rd) chk("rd_addr", rd_addr, m_reads);
      chk("dp_valid", dp_valid, m_prev_rd);
      if (m_prev_rd) chk("dp_pixel", dp_pixel, src[m_prev_addr]);
      chk("dp_bright", dp_brightness, m_bright);
      chk("wr_en", wr_en, e_wr);
      if (e_wr) begin
        chk("wr_addr", wr_addr, q_addr[0]);
        chk("wr_data", wr_data, sat(src[q_addr[0]], m_bright));
      end
      if (m_phase == 3) chk("done_wr_addr", wr_addr, m_writes % (1 << BA));
      if (wr_en) fr_wr++;
      if (done) begin done_cnt++; last_done_cyc = cyc; end

      ph = m_phase;
      if (e_wr) begin void'(q_addr.pop_front()); void'(q_due.pop_front()); m_writes++; end
      m_prev_rd = e_rd;
      m_prev_addr = m_reads;
      case (ph)
        0: if (start) begin
             m_phase = 1; m_reads = 0; m_writes = 0; m_bright = cfg;
             m_start_cyc = cyc; fr_wr = 0;
           end
        1: begin
             if (e_rd) begin q_addr.push_back(m_reads); q_due.push_back(cyc + 2); m_reads++; end
             if (abort_sig || m_reads == NPIX) m_phase = 2;
           end
        2: if (q_due.size() == 0) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit rnd_pause);
    int c0;
    bit got;
    c0 = done_cnt;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (rnd_pause) pause = ($urandom_range(0, 3) == 0);
      tick();
      if (done_cnt != c0) got = 1;
    end
    pause = 0;
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic launch(input int b);
    cfg = b[7:0];
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic rand_src();
    for (int i = 0; i < NPIX; i++) src[i] = $urandom_range(0, 255);
  endtask

  int lit_src [6] = '{0, 30, 50, 51, 200, 255};
  int lit_dst [6] = '{0, 0, 0, 1, 150, 205};
  int td1, b;

  initial begin
    rst = 1; start = 0; cfg = 8'd0; pause = 0;
`ifdef BRIGHT_FRAME_CTRL_ABORT_EN
    abort = 0;
`endif
    rand_src();
    for (int i = 0; i < 6; i++) src[i] = lit_src[i];
    for (int i = 0; i < NPIX; i++) dst[i] = -1;
    repeat (3) tick();
    rst = 0;
    tick();

    // Basic 4x4 frame with brightness 50
    launch(50);
    wait_done(0);
    chk("lat_basic", last_done_cyc - m_start_cyc, 19);
    chk("wr_count_basic", fr_wr, 16);
    for (int i = 0; i < 6; i++) chk("dst_literal", dst[i], lit_dst[i]);
    tick();

    // Pause for 3 cycles after the 5th read
    launch(50);
    repeat (5) tick();
    pause = 1;
    repeat (3) tick();
    pause = 0;
    wait_done(0);
    chk("lat_pause", last_done_cyc - m_start_cyc, 22);
    chk("wr_count_pause", fr_wr, 16);
    tick();

    // Second start and cfg change mid-frame are ignored
    rand_src();
    launch(80);
    repeat (3) tick();
    start = 1; cfg = 8'd10;
    repeat (5) tick();
    start = 0;
    wait_done(0);
    chk("bright_kept", dp_brightness, 80);
    for (int i = 0; i < NPIX; i++) chk("dst_cfg", dst[i], sat(src[i], 80));
    tick();

    // Reset at the 7th read, then a clean frame
    launch(40);
    repeat (6) tick();
    rst = 1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rd_en", rd_en, 0);
    chk("async_rst_dp_valid", dp_valid, 0);
    repeat (2) tick();
    rst = 0;
    repeat (4) tick();
    rand_src();
    b = $urandom_range(0, 255);
    launch(b);
    wait_done(1);
    chk("wr_count_after_rst", fr_wr, 16);
    for (int i = 0; i < NPIX; i++) chk("dst_after_rst", dst[i], sat(src[i], b));
    tick();

    // Back-to-back frames with start held high
    cfg = 8'd25; start = 1;
    wait_done(0);
    td1 = last_done_cyc;
    tick();
    start = 0;
    wait_done(0);
    chk("b2b_spacing", last_done_cyc - td1, 20);
    chk("b2b_wr_count", fr_wr, 16);
    tick();

    // Randomized frames with random pause patterns
    for (int f = 0; f < 4; f++) begin
      rand_src();
      b = $urandom_range(0, 255);
      launch(b);
      wait_done(1);
      chk("rand_wr_count", fr_wr, 16);
      for (int i = 0; i < NPIX; i++) chk("dst_rand", dst[i], sat(src[i], b));
      repeat ($urandom_range(1, 3)) tick();
    end

`ifdef BRIGHT_FRAME_CTRL_ABORT_EN
    // Abort after the 6th read
    launch(60);
    repeat (6) tick();
    abort = 1;
    tick();
    abort = 0;
    wait_done(0);
    chk("abort_wr_count", fr_wr, 6);
    tick();
    chk("abort_idle", busy, 0);
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
